// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply-divide controller: 32-iteration shift-add multiply and
// restoring divide, sign fix-up cycle, MTHI/MTLO writes, cancel and div-by-zero.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO and div-by-zero handled here
  // RUN   | 32 shift-add / restoring-divide iterations, then one hand-off cycle
  // FIX   | sign correction, hi/lo write and done pulse
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] acc;
  logic [31:0] low;
  logic [31:0] opa;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;

  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[31];
    rt_neg    = signed_op & rt_data[31];
    rs_mag    = rs_neg ? (32'd0 - rs_data) : rs_data;
    rt_mag    = rt_neg ? (32'd0 - rt_data) : rt_data;
    mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opa} : 33'd0);
    // remainder stays below the divisor, so bit 32 is a clean borrow flag
    div_diff  = {acc, low[31]} - {1'b0, opa};
    prod_fix  = neg_res ? (64'd0 - {acc, low}) : {acc, low};
    quot_fix  = neg_res ? (32'd0 - low) : low;
    rem_fix   = neg_rem ? (32'd0 - acc) : acc;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      low         <= '0;
      opa         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= rs_data;
            end else if (op == OP_MTLO) begin
              lo <= rs_data;
            end else if (!op[2]) begin
              if (op[1] && (rt_data == 32'd0)) begin
                done        <= 1'b1;
                div_by_zero <= 1'b1;
              end else begin
                is_div  <= op[1];
                opa     <= op[1] ? rt_mag : rs_mag;
                low     <= op[1] ? rs_mag : rt_mag;
                acc     <= '0;
                cnt     <= '0;
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= rs_neg;
                state   <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt == 6'd32) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 6'd1;
            if (!is_div) begin
              {acc, low} <= {mul_sum, low[31:1]};
            end else if (!div_diff[32]) begin
              acc <= div_diff[31:0];
              low <= {low[30:0], 1'b1};
            end else begin
              acc <= {acc[30:0], low[31]};
              low <= {low[30:0], 1'b0};
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            hi   <= is_div ? rem_fix  : prod_fix[63:32];
            lo   <= is_div ? quot_fix : prod_fix[31:0];
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  hilo_muldiv_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    step();
    start   = 1'b0;
    op      = 3'b111;
  endtask

  // Runs a full operation and checks latency, pulse width and results.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bit early_done = 0;
    bit busy_gap = 0;
    issue(o, a, b);
    for (int i = 1; i <= 34; i++) begin
      if (done) early_done = 1;
      if (!busy) busy_gap = 1;
      step();
    end
    checks++;
    if (early_done !== 1'b0 || busy_gap !== 1'b0) begin
      failures++;
      $display("FAIL %s_timing: early_done=%0d busy_gap=%0d required 0 0", name, early_done, busy_gap);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: done=%b busy=%b dbz=%b required 1 0 0", name, done, busy, div_by_zero);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: done=%b required 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    do_op("mult",  3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
  endtask

  task automatic test_div();
    do_op("div_neg",  3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu",     3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    do_op("div_ovf",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op("divu_big", 3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
  endtask

  task automatic test_mthi_mtlo_divzero();
    issue(3'b100, 32'h11111111, 32'h0);
    checks++;
    if (hi !== 32'h11111111 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h busy=%b done=%b required 11111111 0 0", hi, busy, done);
    end
    issue(3'b101, 32'h22222222, 32'h0);
    checks++;
    if (lo !== 32'h22222222 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: lo=%h busy=%b done=%b required 22222222 0 0", lo, busy, done);
    end
    issue(3'b011, 32'h00000009, 32'h0);
    checks++;
    if (done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL divzero_flag: done=%b dbz=%b busy=%b required 1 1 0", done, div_by_zero, busy);
    end
    checks++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      failures++;
      $display("FAIL divzero_hilo: hi=%h lo=%h required 11111111 22222222", hi, lo);
    end
    step();
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL divzero_after: done=%b dbz=%b busy=%b required 0 0 0", done, div_by_zero, busy);
    end
  endtask

  task automatic test_busy_cancel();
    bit saw_done = 0;
    issue(3'b001, 32'd5, 32'd6);
    step();
    // MTHI issued while busy must not touch hi
    issue(3'b100, 32'hDEADBEEF, 32'h0);
    checks++;
    if (busy !== 1'b1 || hi !== 32'h11111111) begin
      failures++;
      $display("FAIL start_while_busy: busy=%b hi=%h required 1 11111111", busy, hi);
    end
    for (int i = 0; i < 7; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL cancel_state: busy=%b done=%b required 0 0", busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      failures++;
      $display("FAIL cancel_hilo: saw_done=%0d hi=%h lo=%h required 0 11111111 22222222",
               saw_done, hi, lo);
    end
  endtask

  task automatic test_cancel_idle_reserved();
    cancel = 1'b1;
    step();
    issue(3'b110, 32'h55555555, 32'h1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      failures++;
      $display("FAIL reserved_op: busy=%b done=%b hi=%h lo=%h required 0 0 11111111 22222222",
               busy, done, hi, lo);
    end
    issue(3'b001, 32'd7, 32'd9);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_with_cancel: busy=%b required 1", busy);
    end
    for (int i = 0; i < 34; i++) step();
    checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd63) begin
      failures++;
      $display("FAIL start_with_cancel_result: done=%b hi=%h lo=%h required 1 0 3f", done, hi, lo);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    issue(3'b010, 32'd100, 32'd7);
    for (int i = 0; i < 19; i++) step();
    reset_n = 1'b0;
    start   = 1'b1;
    cancel  = 1'b1;
    op      = 3'b100;
    rs_data = 32'hABCDABCD;
    step();
    start   = 1'b0;
    cancel  = 1'b0;
    reset_n = 1'b1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b hi=%h lo=%h required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    do_op("mult_after_reset", 3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_1", 3'b011, 32'd1000, 32'd33, 32'd10, 32'd30);
    do_op("b2b_2", 3'b000, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000);
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    op      = 3'b111;
    rs_data = '0;
    rt_data = '0;
    cancel  = 1'b0;
    #2;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_divzero();
    test_busy_cancel();
    test_cancel_idle_reserved();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
